// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with per-stage valid, bubble collapsing and global flush.
// Latency: DEPTH-1 cycles from the accept edge to out_valid when no backpressure is applied.
// Backpressure: out_ready low stalls only the full tail of the chain; in_ready drops only when every stage is full (or on flush).
// Optional: define PIPE_STALL_CNT_EN to add a saturating 32-bit stall_cnt output.
module pipe_reg_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0]                stall_cnt
`endif
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]            v_q;
   logic [DEPTH-1:0]            v_d;
   logic [DEPTH-1:0][WIDTH-1:0] d_q;
   logic [DEPTH-1:0][WIDTH-1:0] d_d;
   logic [DEPTH-1:0]            adv;
   logic                        in_fire;
   logic [OCC_W-1:0]            occ_c;

   // Advance terms: a stage may move when downstream takes the output or any stage
   // from here to the output is empty. Folded into a running AND so there is no
   // self-referencing vector chain.
   always_comb begin : adv_chain
      logic all_full;
      all_full = 1'b1;
      adv      = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         all_full = all_full & v_q[i];
         adv[i]   = out_ready | ~all_full;
      end
   end

   // Accept decision has no dependency on in_valid, only on state, out_ready and flush.
   assign in_ready = adv[0] & ~flush;
   assign in_fire  = in_valid & in_ready;

   // Next-state: flush clears valids (data holds); otherwise advancing stages take their source.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = '0;
      end else begin
         if (adv[0]) begin
            v_d[0] = in_fire;
            if (in_fire) begin
               d_d[0] = in_data;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
               v_d[i] = v_q[i-1];
               if (v_q[i-1]) begin
                  d_d[i] = d_q[i-1];
               end
            end
         end
      end
   end

   // Stage registers; reset drops every payload immediately.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   // Occupancy is the number of valid stages in the current state.
   always_comb begin
      occ_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_c = occ_c + OCC_W'(v_q[i]);
      end
   end

   assign occupancy = occ_c;
   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Count cycles where the output is offered but refused; saturate instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter survives flush; only reset clears it.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (DEPTH=4, WIDTH=32).
// Driver pushes expected payloads on accept; monitor pops on each output transfer.
// Directed vectors cover reset, streaming, fill, bubbles, full-chain swap, flush and async reset.
module tb_pipe_reg_chain;

   logic        CLK;
   logic        RST_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        flush;
   logic [2:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   pipe_reg_chain #(.WIDTH(32), .DEPTH(4)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Drive one cycle; decide accept/flush at negedge+1, after the monitor has run.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(negedge CLK);
      #1;
      if (fl) begin
         exp_q.delete();
      end else if (iv && in_ready) begin
         exp_q.push_back(id);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int k = 0; k < n; k++) step(1'b0, 32'h0, ordy, 1'b0);
   endtask

   // Pulse reset between edges and check outputs before any clock edge.
   task automatic reset_pulse();
      in_valid = 1'b0;
      flush    = 1'b0;
      #1 RST_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_out_data", out_data, 32'd0);
      chk("arst_occupancy", {29'b0, occupancy}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_STALL_CNT_EN
      chk("arst_stall_cnt", stall_cnt, 32'd0);
`endif
      exp_q.delete();
      #1 RST_n = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   // Monitor: every output transfer must match the head of the expected queue.
   always @(negedge CLK) begin
      if (RST_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected actual=%0h required=none", out_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (out_data !== exp_v) begin
               failures++;
               $display("FAIL out_data actual=%0h required=%0h", out_data, exp_v);
            end
         end
      end
   end

   initial begin
      RST_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      #1 RST_n  = 1'b0;
      #2;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge CLK);
      RST_n = 1'b1;
      @(posedge CLK);
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Streaming: 1..5 with out_ready high; first output after the 4th edge.
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 32'(k + 1), 1'b1, 1'b0);
         chk("stream_out_valid", {31'b0, out_valid}, (k >= 3) ? 32'd1 : 32'd0);
         if (k == 3) chk("stream_first_data", out_data, 32'd1);
      end
      chk("stream_occupancy", {29'b0, occupancy}, 32'd4);
      idle(4, 1'b1);
      chk("stream_drained", {29'b0, occupancy}, 32'd0);

      // Backpressure fill: A0..A3 with out_ready low.
      for (int k = 0; k < 4; k++) step(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0);
      chk("fill_occupancy", {29'b0, occupancy}, 32'd4);
      chk("fill_out_data", out_data, 32'hA0);
      in_valid = 1'b1; in_data = 32'hEE; out_ready = 1'b0; flush = 1'b0;
      #1;
      chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
      step(1'b1, 32'hEE, 1'b0, 1'b0);
      chk("fill_hold_data", out_data, 32'hA0);
      chk("fill_hold_occ", {29'b0, occupancy}, 32'd4);

      // Full chain: simultaneous in and out.
      in_valid = 1'b1; in_data = 32'hB0; out_ready = 1'b1;
      #1;
      chk("full_in_ready", {31'b0, in_ready}, 32'd1);
      step(1'b1, 32'hB0, 1'b1, 1'b0);
      chk("full_occupancy", {29'b0, occupancy}, 32'd4);
      chk("full_next_data", out_data, 32'hA1);
      idle(4, 1'b1);
      chk("full_drained", {29'b0, occupancy}, 32'd0);

      // Bubble collapse.
      step(1'b1, 32'h11, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b1, 32'h22, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("bubble_occupancy", {29'b0, occupancy}, 32'd2);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #1;
      chk("bubble_in_ready", {31'b0, in_ready}, 32'd1);
      chk("bubble_out_data", out_data, 32'h11);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bubble_second_valid", {31'b0, out_valid}, 32'd1);
      chk("bubble_second_data", out_data, 32'h22);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bubble_empty", {29'b0, occupancy}, 32'd0);

      // Flush with three in flight; the flush-cycle input must never appear.
      for (int k = 0; k < 3; k++) step(1'b1, 32'hC1 + 32'(k), 1'b0, 1'b0);
      chk("flush_pre_occ", {29'b0, occupancy}, 32'd3);
      in_valid = 1'b1; in_data = 32'hDD; out_ready = 1'b0; flush = 1'b1;
      #1;
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      step(1'b1, 32'hDD, 1'b0, 1'b1);
      chk("flush_occupancy", {29'b0, occupancy}, 32'd0);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      idle(4, 1'b1);
      chk("flush_stays_empty", {29'b0, occupancy}, 32'd0);

      // Flush while the output transfers: E0 is delivered, the rest dropped.
      for (int k = 0; k < 4; k++) step(1'b1, 32'hE0 + 32'(k), 1'b0, 1'b0);
      step(1'b1, 32'hEF, 1'b1, 1'b1);
      chk("flushx_occupancy", {29'b0, occupancy}, 32'd0);
      chk("flushx_out_valid", {31'b0, out_valid}, 32'd0);
      idle(3, 1'b1);

      // Stall counting and async reset mid-transfer.
      reset_pulse();
      step(1'b1, 32'h77, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      idle(7, 1'b0);
`ifdef PIPE_STALL_CNT_EN
      chk("stall_cnt_7", stall_cnt, 32'd7);
`endif
      reset_pulse();
      step(1'b1, 32'h99, 1'b1, 1'b0);
      idle(4, 1'b1);
      chk("post_arst_empty", {29'b0, occupancy}, 32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
